// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen bus bridges: bridge state encoding
// and byte-strobe to bit-mask expansion.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } bridge_state_e;

    function automatic logic [7:0] strobe_to_byte_mask(input logic strobe);
        return {8{strobe}};
    endfunction

endpackage

// File: rtl/rggen_bus_timeout_counter.sv
// Counts cycles spent waiting for a register response and flags the cycle in
// which the wait limit is reached; TIMEOUT_CYCLES of 0 never expires.
module rggen_bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT =
        COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the last permitted waiting cycle, so a response arriving in
    // that same cycle can still take priority in the bridge.
    assign expired = (TIMEOUT_CYCLES > 0) && enable && (count == LAST_COUNT);

endmodule

// File: rtl/rggen_apb_command_bridge.sv
// APB slave front end that turns each transfer into one register command and
// returns the register block's response (or a timeout error) to the APB master.
//
// state      | meaning
// ST_IDLE    | waiting for an APB setup phase
// ST_BUSY    | command driven, waiting for response or timeout
// ST_RESPOND | pready high for one cycle with the latched response
module rggen_apb_command_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_psel,
    input  logic                      i_penable,
    input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
    input  logic                      i_pwrite,
    input  logic [DATA_WIDTH-1:0]     i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
    output logic                      o_pready,
    output logic [DATA_WIDTH-1:0]     o_prdata,
    output logic                      o_pslverr,
    output logic                      o_command_valid,
    output logic [ADDRESS_WIDTH-1:0]  o_command_address,
    output logic                      o_command_write,
    output logic [DATA_WIDTH-1:0]     o_command_write_data,
    output logic [DATA_WIDTH-1:0]     o_command_write_mask,
    input  logic                      i_response_ready,
    input  logic [DATA_WIDTH-1:0]     i_response_read_data,
    input  logic                      i_response_error
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    bridge_state_e           state;
    logic                    timeout_expired;
    logic [DATA_WIDTH-1:0]   mask_next;

    always_comb begin
        mask_next = '1;
        if (i_pwrite) begin
            for (int n = 0; n < STRB_WIDTH; n++) begin
                mask_next[8*n +: 8] = strobe_to_byte_mask(i_pstrb[n]);
            end
        end
    end

    rggen_bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ST_IDLE),
        .enable  ((state == ST_BUSY) && !i_response_ready),
        .expired (timeout_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            o_pready             <= 1'b0;
            o_prdata             <= '0;
            o_pslverr            <= 1'b0;
            o_command_valid      <= 1'b0;
            o_command_address    <= '0;
            o_command_write      <= 1'b0;
            o_command_write_data <= '0;
            o_command_write_mask <= '0;
        end else begin
            o_pready  <= 1'b0;
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_psel && !i_penable) begin
                        o_command_valid      <= 1'b1;
                        o_command_address    <= i_paddr;
                        o_command_write      <= i_pwrite;
                        o_command_write_data <= i_pwdata;
                        o_command_write_mask <= mask_next;
                        state                <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // APB signals are not looked at here: a master that drops
                    // psel mid-transfer still gets its command completed.
                    if (i_response_ready) begin
                        o_command_valid <= 1'b0;
                        o_pready        <= 1'b1;
                        o_prdata        <= o_command_write ? '0 : i_response_read_data;
                        o_pslverr       <= i_response_error;
                        state           <= ST_RESPOND;
                    end else if (timeout_expired) begin
                        o_command_valid <= 1'b0;
                        o_pready        <= 1'b1;
                        o_pslverr       <= 1'b1;
                        state           <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    state <= ST_IDLE;
                end
                default: begin
                    o_command_valid <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rggen_apb_command_bridge.md
RGGEN_APB_COMMAND_BRIDGE -- requirements
Module: rggen_apb_command_bridge

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16, byte address width of APB and command address.
REQ-002 Parameter DATA_WIDTH, default 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles waiting for response; 0 disables timeout.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_psel  input  1  APB select.
REQ-007 i_penable  input  1  APB enable (access phase).
REQ-008 i_paddr  input  ADDRESS_WIDTH  APB address.
REQ-009 i_pwrite  input  1  APB write (1) / read (0).
REQ-010 i_pwdata  input  DATA_WIDTH  APB write data.
REQ-011 i_pstrb  input  DATA_WIDTH/8  APB byte strobes.
REQ-012 o_pready  output  1  APB ready.
REQ-013 o_prdata  output  DATA_WIDTH  APB read data.
REQ-014 o_pslverr  output  1  APB error.
REQ-015 o_command_valid  output  1  register command valid, fanned to all fields.
REQ-016 o_command_address  output  ADDRESS_WIDTH  command address, used for field select decode.
REQ-017 o_command_write  output  1  command is write.
REQ-018 o_command_write_data  output  DATA_WIDTH  write data.
REQ-019 o_command_write_mask  output  DATA_WIDTH  per-bit write mask.
REQ-020 i_response_ready  input  1  register block accepted/completed command.
REQ-021 i_response_read_data  input  DATA_WIDTH  read data, valid with i_response_ready.
REQ-022 i_response_error  input  1  no register hit / access error, valid with i_response_ready.

Function
REQ-023 States IDLE, BUSY, RESPOND; reset state IDLE.
REQ-024 IDLE: on i_psel=1 and i_penable=0, latch paddr/pwrite/pwdata/pstrb into command registers and go to BUSY.
REQ-025 BUSY: o_command_valid=1 every cycle; command registers stable.
REQ-026 Write mask: byte n of o_command_write_mask = 8 copies of i_pstrb[n] for writes; all ones for reads.
REQ-027 BUSY with i_response_ready=1: register read_data (forced 0 for writes) and error, o_command_valid=0 next cycle, go to RESPOND.
REQ-028 RESPOND: o_pready=1 for exactly one cycle with registered o_prdata/o_pslverr, then IDLE.
REQ-029 Minimum latency: setup at T0, command_valid at T1, ready at T1 gives o_pready at T2.
REQ-030 Timeout: counter of width clog2(TIMEOUT_CYCLES+1) increments each BUSY cycle without ready; at count == TIMEOUT_CYCLES-1 with no ready, go to RESPOND with pslverr=1, prdata=0.
REQ-031 Ready in the same cycle the timeout fires: ready wins, its response returned.
REQ-032 o_pready, o_pslverr SHALL be 0 and o_prdata 0 outside RESPOND.
REQ-033 i_psel dropping during BUSY (protocol violation): command completes normally; RESPOND still one cycle; no new setup accepted until IDLE.
REQ-034 Setup phase present while in BUSY/RESPOND is ignored; only accepted in IDLE.

Reset
REQ-035 On rst_n=0: state IDLE, all outputs 0, command registers 0, timeout counter 0, immediately and irrespective of clk; in-flight transfer abandoned without response.

Structure
REQ-036 Shared package rggen_rtl_pkg SHALL hold the state enum type and the strobe-to-bit-mask expansion function.
REQ-037 Timeout counting SHALL be sub-module rggen_bus_timeout_counter (inputs clear, count enable; output expired).

Verification
REQ-038 Write 0x12345678 to 0x0010, pstrb=4'b0011, ready at T1 -> command_write_mask 0x0000FFFF, data 0x12345678, pready=1 at T2, pslverr=0.
REQ-039 Read 0x0020, ready after 3 BUSY cycles with read_data 0xA5A5_0001 -> command_valid high 4 cycles, prdata 0xA5A50001, mask 0xFFFFFFFF.
REQ-040 TIMEOUT_CYCLES=4, read never ready -> command_valid high 4 cycles, then pready=1, pslverr=1, prdata 0.
REQ-041 Ready with error=1 on write -> pslverr=1, prdata 0; next setup accepted in following cycle.
REQ-042 rst_n asserted during BUSY -> command_valid 0 immediately; after release, new read completes normally.
REQ-043 TIMEOUT_CYCLES=0, ready after 1000 cycles -> no timeout, normal response.
